activation_writeback: RTL and testbench

Consumer for the activation stage output. It accepts the 8-bit activation stream one element per handshake and packs LANES elements into one word, little-endian. Each packed word is written to the unified buffer at consecutive addresses, with a byte strobe for a partial final word. One job is one row of row_len elements, launched by start.

---
 rtl/activation_writeback_if.sv | 35 +++
 rtl/activation_writeback.sv | 132 +++++++++++++
 tb/tb_activation_writeback.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/activation_writeback_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | activation_writeback_if : job control, activation stream, buffer write |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface activation_writeback_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ADDR_W = 8
);
  logic                     start;
  logic [ADDR_W-1:0]        base_addr;
  logic [ADDR_W-1:0]        row_len;
  logic                     act_valid;
  logic [DATA_W-1:0]        act_data;
  logic                     act_ready;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W*LANES-1:0]  wr_data;
  logic [LANES-1:0]         wr_strb;
  logic                     wr_ready;
  logic                     busy;
  logic                     done;

  modport master (
    output start, base_addr, row_len, act_valid, act_data, wr_ready,
    input  act_ready, wr_en, wr_addr, wr_data, wr_strb, busy, done
  );

  modport slave (
    input  start, base_addr, row_len, act_valid, act_data, wr_ready,
    output act_ready, wr_en, wr_addr, wr_data, wr_strb, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/activation_writeback.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | activation_writeback : packs activations LANES-wide, writes to buffer  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module activation_writeback #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  activation_writeback_if.slave  s_bus
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WORD_W = DATA_W * LANES;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [LANE_W-1:0]   r_lane;
  logic [ADDR_W-1:0]   r_remaining;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_data;
  logic [LANES-1:0]    r_strb;

  logic w_act_ready;
  logic w_wr_en;
  logic w_busy;
  logic w_done;
  logic w_accept;
  logic w_retire;
  logic w_last_lane;
  logic w_last_elem;
  logic w_start_job;

  assign w_accept    = s_bus.act_valid && w_act_ready;
  assign w_retire    = w_wr_en && s_bus.wr_ready;
  assign w_last_lane = (r_lane == LANE_W'(LANES - 1));
  assign w_last_elem = (r_remaining == ADDR_W'(1));
  assign w_start_job = (r_state == S_IDLE) && s_bus.start && (s_bus.row_len != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_act_ready = 1'b0;
    w_wr_en     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (s_bus.start) begin
          w_next = (s_bus.row_len != '0) ? S_COLLECT : S_DONE;
        end
      end
      S_COLLECT: begin
        w_act_ready = 1'b1;
        w_busy      = 1'b1;
        if (s_bus.act_valid && (w_last_lane || w_last_elem)) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_wr_en = 1'b1;
        w_busy  = 1'b1;
        if (s_bus.wr_ready) begin
          w_next = (r_remaining == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Unwritten lanes stay zero because the word is cleared on start and on every retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane      <= '0;
      r_remaining <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_strb      <= '0;
    end else if (w_start_job) begin
      r_addr      <= s_bus.base_addr;
      r_remaining <= s_bus.row_len;
      r_lane      <= '0;
      r_data      <= '0;
      r_strb      <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (r_lane == LANE_W'(k)) begin
          r_data[k*DATA_W +: DATA_W] <= s_bus.act_data;
          r_strb[k]                  <= 1'b1;
        end
      end
      r_lane      <= r_lane + LANE_W'(1);
      r_remaining <= r_remaining - ADDR_W'(1);
    end else if (w_retire) begin
      r_addr <= r_addr + ADDR_W'(1);
      r_lane <= '0;
      r_data <= '0;
      r_strb <= '0;
    end
  end

  assign s_bus.act_ready = w_act_ready;
  assign s_bus.wr_en     = w_wr_en;
  assign s_bus.wr_addr   = r_addr;
  assign s_bus.wr_data   = r_data;
  assign s_bus.wr_strb   = r_strb;
  assign s_bus.busy      = w_busy;
  assign s_bus.done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_activation_writeback.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_activation_writeback : random jobs vs. a packed-word reference list |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_activation_writeback;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int ADDR_W = 8;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  activation_writeback_if #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

  activation_writeback #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         n_wr = 0;
  int         ready_pct = 100;
  bit         stall_arm = 0;
  int         stall_cyc = 0;
  bit         check_retire = 0;
  logic [7:0] elems [0:255];
  wr_t        exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected writes: element i lands in word i/4, lane i%4, at base + i/4.
  function automatic void build_expect(input logic [7:0] base, input int len);
    wr_t w;
    for (int i = 0; i < len; i += 4) begin
      w.addr = base + 8'(i / 4);
      w.data = '0;
      w.strb = '0;
      for (int k = 0; k < 4 && i + k < len; k++) begin
        w.data[k*8 +: 8] = elems[i + k];
        w.strb[k]        = 1'b1;
      end
      exp_q.push_back(w);
    end
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 256; i++) elems[i] = 8'($urandom);
  endtask

  task automatic check_reset_outs();
    chk("rst_act_ready", bus.act_ready, 0);
    chk("rst_wr_en",     bus.wr_en,     0);
    chk("rst_wr_addr",   bus.wr_addr,   0);
    chk("rst_wr_data",   bus.wr_data,   0);
    chk("rst_wr_strb",   bus.wr_strb,   0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_done",      bus.done,      0);
  endtask

  always @(posedge clk) cyc_cnt++;

  initial begin
    bus.wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_arm) begin
        if (bus.wr_en) stall_cyc++;
        if (stall_cyc > 5) begin
          stall_arm    = 0;
          bus.wr_ready = 1'b1;
          check_retire = 1;
        end else begin
          bus.wr_ready = 1'b0;
        end
      end else begin
        bus.wr_ready = ($urandom_range(99) < ready_pct);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("ready_while_write", bus.wr_en & bus.act_ready, 0);
      if (bus.wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          chk("wr_addr", bus.wr_addr, exp_q[0].addr);
          chk("wr_data", bus.wr_data, exp_q[0].data);
          chk("wr_strb", bus.wr_strb, exp_q[0].strb);
          if (bus.wr_ready) begin
            void'(exp_q.pop_front());
            n_wr++;
          end
        end
      end
      if (check_retire) begin
        chk("stall_retire", bus.wr_en & bus.wr_ready, 1);
        check_retire = 0;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge with the DUT idle.
  task automatic run_job(input logic [7:0] base, input int len, input int pvalid, input bit spurious);
    int idx, guard, snap, words, start_cyc;
    bit acc, first, spur_done, clean;
    clean = (pvalid == 100) && (ready_pct == 100) && !stall_arm;
    build_expect(base, len);
    words = (len + 3) / 4;
    snap  = done_cnt;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.row_len   = 8'(len);
    @(posedge clk); #1;
    start_cyc     = cyc_cnt;
    bus.start     = 1'b0;
    bus.base_addr = 8'($urandom);
    bus.row_len   = 8'($urandom);
    if (len == 0) begin
      @(negedge clk);
      chk("zero_len_done", bus.done, 1);
      chk("zero_len_busy", bus.busy, 0);
      @(posedge clk); #1;
    end
    idx = 0; guard = 0; first = 1; spur_done = 0;
    while (idx < len && guard < 4000) begin
      bus.act_valid = ($urandom_range(99) < pvalid);
      bus.act_data  = bus.act_valid ? elems[idx] : 8'($urandom);
      if (spurious && !spur_done && idx == 2) begin
        spur_done     = 1;
        bus.start     = 1'b1;
        bus.base_addr = 8'($urandom);
        bus.row_len   = 8'($urandom_range(255, 1));
      end
      @(negedge clk);
      if (first) begin
        chk("busy_after_start", bus.busy, 1);
        chk("done_after_start", bus.done, 0);
        first = 0;
      end
      acc = bus.act_valid && bus.act_ready;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (acc) idx++;
      guard++;
    end
    bus.act_valid = 1'b0;
    chk("elements_fed", idx, len);
    guard = 0;
    while (done_cnt == snap && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("done_pulses", done_cnt - snap, 1);
    chk("writes_left", exp_q.size(), 0);
    if (clean) chk("latency", done_cyc - start_cyc, len + words);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before, r, len;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.row_len   = '0;
    bus.act_valid = 1'b0;
    bus.act_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) elems[i] = 8'(i + 1);
    run_job(8'h10, 8, 100, 0);

    elems[0] = 8'h0C; elems[1] = 8'h00; elems[2] = 8'h08;
    elems[3] = 8'hFF; elems[4] = 8'h12; elems[5] = 8'h07;
    run_job(8'h33, 6, 100, 0);

    fill_random();
    stall_cyc = 0;
    stall_arm = 1;
    run_job(8'h80, 8, 100, 0);

    run_job(8'h55, 0, 100, 0);

    fill_random();
    run_job(8'h60, 10, 100, 1);

    fill_random();
    run_job(8'hFF, 8, 100, 0);

    // Abort a job after three elements; the partial word must never be written.
    fill_random();
    bus.start     = 1'b1;
    bus.base_addr = 8'h40;
    bus.row_len   = 8'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.act_valid = 1'b1;
      bus.act_data  = elems[i];
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1 check_reset_outs();
    @(posedge clk); #1;
    bus.act_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    wr_before = n_wr;
    fill_random();
    run_job(8'h20, 4, 100, 0);
    chk("writes_after_reset", n_wr - wr_before, 1);

    for (int j = 0; j < 25; j++) begin
      r = $urandom_range(9);
      if (r == 0)      len = 0;
      else if (r == 1) len = $urandom_range(255, 200);
      else             len = $urandom_range(24, 1);
      ready_pct = $urandom_range(100, 30);
      fill_random();
      run_job(8'($urandom), len, $urandom_range(100, 30), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
